// File: rtl/host_mailbox.sv
// Host-side mailbox for bare-metal test programs.
// A core on a req/gnt memory port writes stdout characters to PUTCHAR (buffered in a FIFO)
// and its exit code to TOHOST (latched once). The host writes FROMHOST, and the core polls it.
module host_mailbox #(
   parameter int unsigned          ADDR_W        = 64,
   parameter logic [ADDR_W-1:0]    TOHOST_ADDR   = ADDR_W'(64'h0000_1000),
   parameter logic [ADDR_W-1:0]    FROMHOST_ADDR = ADDR_W'(64'h0000_1008),
   parameter logic [ADDR_W-1:0]    PUTCHAR_ADDR  = ADDR_W'(64'h0000_1010),
   parameter int unsigned          FIFO_DEPTH    = 16
) (
   input  logic              clk_i,
   input  logic              arst_ni,
   input  logic              mem_req_i,
   input  logic              mem_we_i,
   input  logic [ADDR_W-1:0] mem_addr_i,
   input  logic [7:0]        mem_wstrb_i,
   input  logic [63:0]       mem_wdata_i,
   output logic              mem_gnt_o,
   output logic              mem_rvalid_o,
   output logic [63:0]       mem_rdata_o,
   output logic              char_valid_o,
   output logic [7:0]        char_data_o,
   input  logic              char_ready_i,
   output logic              exit_valid_o,
   output logic [63:0]       exit_code_o,
   input  logic              host_wr_i,
   input  logic [63:0]       host_wdata_i
);

   localparam int unsigned PTR_W = $clog2(FIFO_DEPTH);
   localparam int unsigned CNT_W = PTR_W + 1;

   // Address decode ignores the byte offset within the 8-byte register.
   logic hit_tohost, hit_fromhost, hit_putchar;
   assign hit_tohost   = mem_addr_i[ADDR_W-1:3] == TOHOST_ADDR[ADDR_W-1:3];
   assign hit_fromhost = mem_addr_i[ADDR_W-1:3] == FROMHOST_ADDR[ADDR_W-1:3];
   assign hit_putchar  = mem_addr_i[ADDR_W-1:3] == PUTCHAR_ADDR[ADDR_W-1:3];

   // FIFO state
   logic [7:0]       fifo_mem [FIFO_DEPTH];
   logic [PTR_W-1:0] wr_ptr_q, rd_ptr_q;
   logic [CNT_W-1:0] count_q, count_d;
   logic             fifo_full, fifo_empty;

   assign fifo_full  = count_q == CNT_W'(FIFO_DEPTH);
   assign fifo_empty = count_q == '0;

   // Register state
   logic        exit_valid_q;
   logic [63:0] exit_code_q, exit_code_d;
   logic [63:0] fromhost_q, fromhost_merged;
   logic        rvalid_q;
   logic [63:0] rdata_q, rdata_sel;

   // A putchar write that would push into a full FIFO is the only stall condition; a pop in
   // the same cycle does not free the slot early.
   logic put_wr, push, pop, rd_acc, wr_acc;
   assign put_wr    = mem_req_i & mem_we_i & hit_putchar & mem_wstrb_i[0];
   assign mem_gnt_o = mem_req_i & ~(put_wr & fifo_full);
   assign push      = put_wr & ~fifo_full;
   assign pop       = ~fifo_empty & char_ready_i;
   assign rd_acc    = mem_gnt_o & ~mem_we_i;
   assign wr_acc    = mem_gnt_o & mem_we_i;

   // Byte-lane handling: tohost zeroes unstrobed lanes, fromhost keeps them.
   always_comb begin
      exit_code_d     = '0;
      fromhost_merged = fromhost_q;
      for (int i = 0; i < 8; i++) begin
         if (mem_wstrb_i[i]) begin
            exit_code_d[8*i +: 8]     = mem_wdata_i[8*i +: 8];
            fromhost_merged[8*i +: 8] = mem_wdata_i[8*i +: 8];
         end
      end
   end

   // Read data mux; putchar and unmapped addresses read as zero.
   always_comb begin
      rdata_sel = '0;
      if (hit_tohost) begin
         rdata_sel = exit_code_q;
      end else if (hit_fromhost) begin
         rdata_sel = fromhost_q;
      end
   end

   // FIFO occupancy next state.
   always_comb begin
      count_d = count_q;
      unique case ({push, pop})
         2'b10:   count_d = count_q + 1'b1;
         2'b01:   count_d = count_q - 1'b1;
         default: count_d = count_q;
      endcase
   end

   // FIFO pointers, occupancy and storage; pointers wrap naturally at the power-of-two depth.
   always_ff @(posedge clk_i or negedge arst_ni) begin
      if (!arst_ni) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
         for (int i = 0; i < FIFO_DEPTH; i++) begin
            fifo_mem[i] <= '0;
         end
      end else begin
         count_q <= count_d;
         if (push) begin
            fifo_mem[wr_ptr_q] <= mem_wdata_i[7:0];
            wr_ptr_q           <= wr_ptr_q + 1'b1;
         end
         if (pop) begin
            rd_ptr_q <= rd_ptr_q + 1'b1;
         end
      end
   end

   // Tohost latch: the first write wins, later writes are accepted but dropped.
   always_ff @(posedge clk_i or negedge arst_ni) begin
      if (!arst_ni) begin
         exit_valid_q <= 1'b0;
         exit_code_q  <= '0;
      end else if (wr_acc && hit_tohost && !exit_valid_q) begin
         exit_valid_q <= 1'b1;
         exit_code_q  <= exit_code_d;
      end
   end

   // Fromhost register: a host write overrides a same-cycle core write with its whole value.
   always_ff @(posedge clk_i or negedge arst_ni) begin
      if (!arst_ni) begin
         fromhost_q <= '0;
      end else if (host_wr_i) begin
         fromhost_q <= host_wdata_i;
      end else if (wr_acc && hit_fromhost) begin
         fromhost_q <= fromhost_merged;
      end
   end

   // Read response: data captured at the grant edge, valid for exactly the following cycle.
   always_ff @(posedge clk_i or negedge arst_ni) begin
      if (!arst_ni) begin
         rvalid_q <= 1'b0;
         rdata_q  <= '0;
      end else begin
         rvalid_q <= rd_acc;
         if (rd_acc) begin
            rdata_q <= rdata_sel;
         end
      end
   end

   assign mem_rvalid_o = rvalid_q;
   assign mem_rdata_o  = rdata_q;
   assign char_valid_o = ~fifo_empty;
   assign char_data_o  = fifo_mem[rd_ptr_q];
   assign exit_valid_o = exit_valid_q;
   assign exit_code_o  = exit_code_q;

endmodule

// File: tb/tb_host_mailbox.sv
// Scoreboard bench for host_mailbox: expected characters and read data are queued as stimulus
// is driven and compared by a monitor when the DUT presents them.
module tb_host_mailbox;

   localparam logic [63:0] TOHOST   = 64'h1000;
   localparam logic [63:0] FROMHOST = 64'h1008;
   localparam logic [63:0] PUTCHAR  = 64'h1010;

   logic        clk = 1'b0;
   logic        arst_n = 1'b0;
   logic        mem_req = 1'b0, mem_we = 1'b0;
   logic [63:0] mem_addr = '0, mem_wdata = '0;
   logic [7:0]  mem_wstrb = '0;
   logic        mem_gnt, mem_rvalid;
   logic [63:0] mem_rdata;
   logic        char_valid, char_ready = 1'b0;
   logic [7:0]  char_data;
   logic        exit_valid;
   logic [63:0] exit_code;
   logic        host_wr = 1'b0;
   logic [63:0] host_wdata = '0;

   int vectors = 0;
   int miscompares = 0;

   logic [7:0]  char_q[$];
   logic [63:0] rd_q[$];
   bit          rd_pend = 1'b0;
   bit          mon_exp;
   logic [63:0] mon_rd;
   logic [7:0]  mon_ch;

   always #5 clk = ~clk;

   host_mailbox dut (
      .clk_i       (clk),
      .arst_ni     (arst_n),
      .mem_req_i   (mem_req),
      .mem_we_i    (mem_we),
      .mem_addr_i  (mem_addr),
      .mem_wstrb_i (mem_wstrb),
      .mem_wdata_i (mem_wdata),
      .mem_gnt_o   (mem_gnt),
      .mem_rvalid_o(mem_rvalid),
      .mem_rdata_o (mem_rdata),
      .char_valid_o(char_valid),
      .char_data_o (char_data),
      .char_ready_i(char_ready),
      .exit_valid_o(exit_valid),
      .exit_code_o (exit_code),
      .host_wr_i   (host_wr),
      .host_wdata_i(host_wdata)
   );

   // Monitor: read responses one cycle after each read, characters whenever popped.
   always @(negedge clk) begin
      if (!arst_n) begin
         rd_pend = 1'b0;
         rd_q.delete();
         vectors++;
         if (mem_rvalid !== 1'b0) begin
            miscompares++;
            $display("FAIL rvalid_in_reset: got %b want 0", mem_rvalid);
         end
      end else begin
         mon_exp = rd_pend;
         rd_pend = mem_req && !mem_we;
         vectors++;
         if (mem_rvalid !== mon_exp) begin
            miscompares++;
            $display("FAIL rvalid_timing: got %b want %b", mem_rvalid, mon_exp);
         end
         if (mon_exp) begin
            vectors++;
            if (rd_q.size() == 0) begin
               miscompares++;
               $display("FAIL rdata_scoreboard: got %h want no pending read", mem_rdata);
            end else begin
               mon_rd = rd_q.pop_front();
               if (mem_rdata !== mon_rd) begin
                  miscompares++;
                  $display("FAIL rdata: got %h want %h", mem_rdata, mon_rd);
               end
            end
         end
         if (char_valid === 1'b1 && char_ready) begin
            vectors++;
            if (char_q.size() == 0) begin
               miscompares++;
               $display("FAIL char_unexpected: got %h want nothing", char_data);
            end else begin
               mon_ch = char_q.pop_front();
               if (char_data !== mon_ch) begin
                  miscompares++;
                  $display("FAIL char_data: got %h want %h", char_data, mon_ch);
               end
            end
         end
      end
   end

   // Drive one bus cycle, starting just after the rising edge.
   task automatic drive(input logic req, input logic we, input logic [63:0] addr,
                        input logic [63:0] wdata, input logic [7:0] strb,
                        input logic hw, input logic [63:0] hdata);
      @(posedge clk);
      #1;
      mem_req    = req;
      mem_we     = we;
      mem_addr   = addr;
      mem_wdata  = wdata;
      mem_wstrb  = strb;
      host_wr    = hw;
      host_wdata = hdata;
   endtask

   task automatic idle(input int n);
      repeat (n) drive(1'b0, 1'b0, '0, '0, '0, 1'b0, '0);
   endtask

   task automatic set_ready(input logic r);
      @(posedge clk);
      #1;
      char_ready = r;
   endtask

   // Let the host pop everything; bounded so a stuck FIFO cannot hang the run.
   task automatic drain_and_check(input int budget);
      set_ready(1'b1);
      for (int i = 0; i < budget && (char_q.size() != 0 || char_valid !== 1'b0); i++) begin
         @(negedge clk);
      end
      vectors++;
      if (char_q.size() != 0 || char_valid !== 1'b0) begin
         miscompares++;
         $display("FAIL drain: got %0d chars left valid=%b want 0 left valid=0",
                  char_q.size(), char_valid);
      end
   endtask

   task automatic test_reset;
      repeat (3) @(negedge clk);
      vectors += 7;
      if (mem_gnt !== 1'b0) begin
         miscompares++; $display("FAIL reset_gnt: got %b want 0", mem_gnt);
      end
      if (mem_rvalid !== 1'b0) begin
         miscompares++; $display("FAIL reset_rvalid: got %b want 0", mem_rvalid);
      end
      if (mem_rdata !== 64'h0) begin
         miscompares++; $display("FAIL reset_rdata: got %h want 0", mem_rdata);
      end
      if (char_valid !== 1'b0) begin
         miscompares++; $display("FAIL reset_char_valid: got %b want 0", char_valid);
      end
      if (char_data !== 8'h00) begin
         miscompares++; $display("FAIL reset_char_data: got %h want 00", char_data);
      end
      if (exit_valid !== 1'b0) begin
         miscompares++; $display("FAIL reset_exit_valid: got %b want 0", exit_valid);
      end
      if (exit_code !== 64'h0) begin
         miscompares++; $display("FAIL reset_exit_code: got %h want 0", exit_code);
      end
      @(posedge clk);
      #1;
      arst_n = 1'b1;
      drive(1'b1, 1'b0, FROMHOST, '0, '0, 1'b0, '0);
      rd_q.push_back(64'h0);
      @(negedge clk);
      vectors++;
      if (mem_gnt !== 1'b1) begin
         miscompares++; $display("FAIL reset_read_gnt: got %b want 1", mem_gnt);
      end
      idle(2);
   endtask

   // "H", "i", "\n" with junk in upper lanes and a lane-0-less write in the middle.
   task automatic test_chars;
      logic [7:0] msg [3];
      msg[0] = 8'h48; msg[1] = 8'h69; msg[2] = 8'h0A;
      set_ready(1'b1);
      for (int i = 0; i < 3; i++) begin
         drive(1'b1, 1'b1, PUTCHAR, {56'hA5A5_A5A5_A5A5_A5, msg[i]}, 8'h01, 1'b0, '0);
         char_q.push_back(msg[i]);
         @(negedge clk);
         vectors++;
         if (mem_gnt !== 1'b1) begin
            miscompares++; $display("FAIL chars_gnt: got %b want 1", mem_gnt);
         end
         if (i == 0) begin
            drive(1'b1, 1'b1, PUTCHAR, 64'h7777_7777_7777_7777, 8'hFE, 1'b0, '0);
            @(negedge clk);
            vectors++;
            if (mem_gnt !== 1'b1) begin
               miscompares++; $display("FAIL chars_nolane0_gnt: got %b want 1", mem_gnt);
            end
         end
      end
      idle(1);
      drain_and_check(20);
   endtask

   task automatic test_full;
      set_ready(1'b0);
      for (int i = 0; i < 16; i++) begin
         drive(1'b1, 1'b1, PUTCHAR, 64'(8'h40 + i), 8'h01, 1'b0, '0);
         char_q.push_back(8'(8'h40 + i));
         @(negedge clk);
         vectors++;
         if (mem_gnt !== 1'b1) begin
            miscompares++; $display("FAIL full_fill_gnt[%0d]: got %b want 1", i, mem_gnt);
         end
      end
      drive(1'b1, 1'b1, PUTCHAR, 64'h50, 8'h01, 1'b0, '0);
      @(negedge clk);
      vectors += 2;
      if (mem_gnt !== 1'b0) begin
         miscompares++; $display("FAIL full_stall_gnt: got %b want 0", mem_gnt);
      end
      if (char_valid !== 1'b1) begin
         miscompares++; $display("FAIL full_char_valid: got %b want 1", char_valid);
      end
      @(negedge clk);
      vectors++;
      if (mem_gnt !== 1'b0) begin
         miscompares++; $display("FAIL full_stall_hold_gnt: got %b want 0", mem_gnt);
      end
      set_ready(1'b1);
      @(negedge clk);
      vectors++;
      if (mem_gnt !== 1'b0) begin
         miscompares++; $display("FAIL full_pop_same_cycle_gnt: got %b want 0", mem_gnt);
      end
      set_ready(1'b0);
      @(negedge clk);
      vectors++;
      if (mem_gnt !== 1'b1) begin
         miscompares++; $display("FAIL full_after_pop_gnt: got %b want 1", mem_gnt);
      end
      char_q.push_back(8'h50);
      idle(1);
      drain_and_check(40);
   endtask

   task automatic test_wrap;
      for (int lap = 0; lap < 2; lap++) begin
         set_ready(1'b0);
         for (int i = 0; i < 16; i++) begin
            drive(1'b1, 1'b1, PUTCHAR, 64'(lap * 16 + i), 8'h01, 1'b0, '0);
            char_q.push_back(8'(lap * 16 + i));
            @(negedge clk);
            vectors++;
            if (mem_gnt !== 1'b1) begin
               miscompares++; $display("FAIL wrap_gnt[%0d]: got %b want 1", lap * 16 + i, mem_gnt);
            end
         end
         idle(1);
         drain_and_check(40);
      end
   endtask

   task automatic test_tohost;
      set_ready(1'b0);
      drive(1'b1, 1'b1, TOHOST, 64'hAAAA_BBBB_0000_0001, 8'h0F, 1'b0, '0);
      @(negedge clk);
      vectors += 2;
      if (mem_gnt !== 1'b1) begin
         miscompares++; $display("FAIL tohost_gnt: got %b want 1", mem_gnt);
      end
      if (exit_valid !== 1'b0) begin
         miscompares++; $display("FAIL tohost_early_valid: got %b want 0", exit_valid);
      end
      drive(1'b1, 1'b1, TOHOST, 64'h55, 8'hFF, 1'b0, '0);
      @(negedge clk);
      vectors += 3;
      if (mem_gnt !== 1'b1) begin
         miscompares++; $display("FAIL tohost_second_gnt: got %b want 1", mem_gnt);
      end
      if (exit_valid !== 1'b1) begin
         miscompares++; $display("FAIL tohost_valid: got %b want 1", exit_valid);
      end
      if (exit_code !== 64'h1) begin
         miscompares++; $display("FAIL tohost_code: got %h want %h", exit_code, 64'h1);
      end
      drive(1'b1, 1'b0, TOHOST, '0, '0, 1'b0, '0);
      rd_q.push_back(64'h1);
      @(negedge clk);
      vectors++;
      if (exit_code !== 64'h1) begin
         miscompares++; $display("FAIL tohost_first_wins: got %h want %h", exit_code, 64'h1);
      end
      idle(2);
   endtask

   task automatic test_fromhost;
      drive(1'b1, 1'b1, FROMHOST, 64'h1, 8'hFF, 1'b1, 64'hDEAD_BEEF);
      @(negedge clk);
      vectors++;
      if (mem_gnt !== 1'b1) begin
         miscompares++; $display("FAIL fromhost_wr_gnt: got %b want 1", mem_gnt);
      end
      drive(1'b1, 1'b0, FROMHOST, '0, '0, 1'b0, '0);
      rd_q.push_back(64'hDEAD_BEEF);
      drive(1'b1, 1'b1, FROMHOST, 64'h1122_3344_5566_7788, 8'h0F, 1'b0, '0);
      idle(1);
      drive(1'b1, 1'b0, FROMHOST, '0, '0, 1'b1, 64'h1234);
      rd_q.push_back(64'h0000_0000_5566_7788);
      drive(1'b1, 1'b0, FROMHOST, '0, '0, 1'b0, '0);
      rd_q.push_back(64'h1234);
      drive(1'b1, 1'b0, TOHOST, '0, '0, 1'b0, '0);
      rd_q.push_back(64'h1);
      drive(1'b1, 1'b0, PUTCHAR, '0, '0, 1'b0, '0);
      rd_q.push_back(64'h0);
      idle(2);
   endtask

   task automatic test_unmapped;
      drive(1'b1, 1'b0, 64'h2000, '0, '0, 1'b0, '0);
      rd_q.push_back(64'h0);
      @(negedge clk);
      vectors++;
      if (mem_gnt !== 1'b1) begin
         miscompares++; $display("FAIL unmapped_read_gnt: got %b want 1", mem_gnt);
      end
      drive(1'b1, 1'b1, 64'h2000, '1, 8'hFF, 1'b0, '0);
      @(negedge clk);
      vectors++;
      if (mem_gnt !== 1'b1) begin
         miscompares++; $display("FAIL unmapped_write_gnt: got %b want 1", mem_gnt);
      end
      drive(1'b1, 1'b0, TOHOST, '0, '0, 1'b0, '0);
      rd_q.push_back(64'h1);
      drive(1'b1, 1'b0, 64'h100F, '0, '0, 1'b0, '0);
      rd_q.push_back(64'h1234);
      idle(2);
      @(negedge clk);
      vectors += 2;
      if (char_valid !== 1'b0) begin
         miscompares++; $display("FAIL unmapped_char_valid: got %b want 0", char_valid);
      end
      if (exit_code !== 64'h1) begin
         miscompares++; $display("FAIL unmapped_exit_code: got %h want %h", exit_code, 64'h1);
      end
   endtask

   task automatic test_reset_mid;
      set_ready(1'b0);
      for (int i = 0; i < 3; i++) begin
         drive(1'b1, 1'b1, PUTCHAR, 64'(8'h61 + i), 8'h01, 1'b0, '0);
      end
      drive(1'b1, 1'b0, TOHOST, '0, '0, 1'b0, '0);
      rd_q.push_back(64'h1);
      @(posedge clk);
      #1;
      mem_req = 1'b0;
      arst_n  = 1'b0;
      #1;
      vectors += 4;
      if (mem_rvalid !== 1'b0) begin
         miscompares++; $display("FAIL midreset_rvalid: got %b want 0", mem_rvalid);
      end
      if (char_valid !== 1'b0) begin
         miscompares++; $display("FAIL midreset_char_valid: got %b want 0", char_valid);
      end
      if (exit_valid !== 1'b0) begin
         miscompares++; $display("FAIL midreset_exit_valid: got %b want 0", exit_valid);
      end
      if (exit_code !== 64'h0) begin
         miscompares++; $display("FAIL midreset_exit_code: got %h want 0", exit_code);
      end
      char_q.delete();
      @(negedge clk);
      @(posedge clk);
      #1;
      arst_n = 1'b1;
      drive(1'b1, 1'b0, FROMHOST, '0, '0, 1'b0, '0);
      rd_q.push_back(64'h0);
      drive(1'b1, 1'b0, TOHOST, '0, '0, 1'b0, '0);
      rd_q.push_back(64'h0);
      idle(3);
      @(negedge clk);
      vectors++;
      if (char_valid !== 1'b0) begin
         miscompares++; $display("FAIL midreset_after_char_valid: got %b want 0", char_valid);
      end
   endtask

   initial begin
      test_reset();
      test_chars();
      test_full();
      test_wrap();
      test_tohost();
      test_fromhost();
      test_unmapped();
      test_reset_mid();
      vectors++;
      if (rd_q.size() != 0) begin
         miscompares++; $display("FAIL reads_outstanding: got %0d want 0", rd_q.size());
      end
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout want completion");
      $fatal(1);
   end

endmodule
